// File: rtl/mesh_noc_pkg.sv
// Shared 2D-mesh NoC definitions: flit type codes, head-flit field layout and head builder.
// Used by the router, the injection NI and the ejection NI.
package mesh_noc_pkg;

    localparam logic [1:0] FLIT_BODY   = 2'b00;
    localparam logic [1:0] FLIT_HEAD   = 2'b01;
    localparam logic [1:0] FLIT_TAIL   = 2'b10;
    localparam logic [1:0] FLIT_SINGLE = 2'b11;

    typedef enum logic [0:0] {
        NI_IDLE = 1'b0,
        NI_BODY = 1'b1
    } ni_state_e;

    function automatic int off_dest_y(input int cx);
        return cx;
    endfunction

    function automatic int off_src_x(input int cx, input int cy);
        return cx + cy;
    endfunction

    function automatic int off_src_y(input int cx, input int cy);
        return 2 * cx + cy;
    endfunction

    function automatic int off_len(input int cx, input int cy);
        return 2 * cx + 2 * cy;
    endfunction

    function automatic logic [63:0] head_field(input logic [31:0] v, input int w, input int off);
        return (64'(v) & ((64'd1 << w) - 64'd1)) << off;
    endfunction

    // Result is 64 bits wide; callers truncate to their flit width.
    function automatic logic [63:0] build_head(
        input int          dw,
        input int          cx,
        input int          cy,
        input int          lenw,
        input logic [1:0]  ftype,
        input logic [31:0] dx,
        input logic [31:0] dy,
        input logic [31:0] sx,
        input logic [31:0] sy,
        input logic [31:0] len
    );
        return head_field(dx, cx, 0)
             | head_field(dy, cy, off_dest_y(cx))
             | head_field(sx, cx, off_src_x(cx, cy))
             | head_field(sy, cy, off_src_y(cx, cy))
             | head_field(len, lenw, off_len(cx, cy))
             | (64'(ftype) << (dw - 2));
    endfunction

endpackage

// File: rtl/mesh_flit_reg.sv
// Single-entry valid/ready output register; accepts new data whenever it is empty or draining.
module mesh_flit_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    input  logic         out_ready_i
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    // Load on accept, clear on drain, otherwise hold data and valid steady.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_valid_i && in_ready_o) begin
            valid_q <= 1'b1;
            data_q  <= in_data_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_q;
        end
    end

endmodule

// File: rtl/mesh_ni_inject.sv
// Injection network interface: turns PE packet requests plus payload words into
// head/body/tail flits on the router's local input port.
module mesh_ni_inject
    import mesh_noc_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int X_COORD     = 0,
    parameter int Y_COORD     = 0,
    parameter int MESH_SIZE_X = 4,
    parameter int MESH_SIZE_Y = 4,
    parameter int MAX_LEN     = 16,
    localparam int CX   = ($clog2(MESH_SIZE_X) > 0) ? $clog2(MESH_SIZE_X) : 1,
    localparam int CY   = ($clog2(MESH_SIZE_Y) > 0) ? $clog2(MESH_SIZE_Y) : 1,
    localparam int LENW = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [CX-1:0]         req_dest_x,
    input  logic [CY-1:0]         req_dest_y,
    input  logic [LENW-1:0]       req_len,
    input  logic [DATA_WIDTH-3:0] pld_data,
    input  logic                  pld_valid,
    output logic                  pld_ready,
    output logic [DATA_WIDTH-1:0] flit_out_data,
    output logic                  flit_out_valid,
    input  logic                  flit_out_ready,
    output logic                  err_bad_req,
    output logic [15:0]           pkt_sent
);

    ni_state_e             state_q;
    logic [LENW-1:0]       rem_q;
    logic                  err_q;
    logic [15:0]           pkt_q;
    logic                  run_q;
    logic                  slot_free;
    logic                  req_fire;
    logic                  pld_fire;
    logic                  req_ok;
    logic                  last_word;
    logic                  load_d;
    logic [DATA_WIDTH-1:0] flit_d;

    // run_q keeps both ready outputs low while reset is (or has just been) asserted.
    assign req_ready   = run_q && (state_q == NI_IDLE) && slot_free;
    assign pld_ready   = run_q && (state_q == NI_BODY) && slot_free;
    assign req_fire    = req_valid && req_ready;
    assign pld_fire    = pld_valid && pld_ready;
    assign req_ok      = (32'(req_dest_x) < 32'(MESH_SIZE_X))
                      && (32'(req_dest_y) < 32'(MESH_SIZE_Y))
                      && (req_len <= LENW'(MAX_LEN));
    assign last_word   = (rem_q == LENW'(1));
    assign err_bad_req = err_q;
    assign pkt_sent    = pkt_q;

    // Select the flit to load: a head/single on a good request, else body/tail on a payload word.
    always_comb begin
        load_d = 1'b0;
        flit_d = '0;
        if (req_fire && req_ok) begin
            load_d = 1'b1;
            flit_d = DATA_WIDTH'(build_head(DATA_WIDTH, CX, CY, LENW,
                                            (req_len == '0) ? FLIT_SINGLE : FLIT_HEAD,
                                            32'(req_dest_x), 32'(req_dest_y),
                                            32'(X_COORD), 32'(Y_COORD), 32'(req_len)));
        end else if (pld_fire) begin
            load_d = 1'b1;
            flit_d = {(last_word ? FLIT_TAIL : FLIT_BODY), pld_data};
        end else begin
            load_d = 1'b0;
            flit_d = '0;
        end
    end

    // Packet FSM, remaining-word counter, error pulse and delivered-packet counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= NI_IDLE;
            rem_q   <= '0;
            err_q   <= 1'b0;
            pkt_q   <= 16'd0;
            run_q   <= 1'b0;
        end else begin
            run_q <= 1'b1;
            err_q <= req_fire && !req_ok;
            // TAIL and SINGLE are the only types with the top bit set.
            if (flit_out_valid && flit_out_ready && flit_out_data[DATA_WIDTH-1]) begin
                pkt_q <= pkt_q + 16'd1;
            end else begin
                pkt_q <= pkt_q;
            end
            case (state_q)
                NI_IDLE: begin
                    if (req_fire && req_ok && (req_len != '0)) begin
                        state_q <= NI_BODY;
                        rem_q   <= req_len;
                    end else begin
                        state_q <= NI_IDLE;
                    end
                end
                NI_BODY: begin
                    if (pld_fire) begin
                        rem_q   <= rem_q - LENW'(1);
                        state_q <= last_word ? NI_IDLE : NI_BODY;
                    end else begin
                        state_q <= NI_BODY;
                    end
                end
                default: begin
                    state_q <= NI_IDLE;
                    rem_q   <= '0;
                end
            endcase
        end
    end

    mesh_flit_reg #(
        .W(DATA_WIDTH)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (load_d),
        .in_data_i  (flit_d),
        .in_ready_o (slot_free),
        .out_valid_o(flit_out_valid),
        .out_data_o (flit_out_data),
        .out_ready_i(flit_out_ready)
    );

endmodule

// File: tb/tb_mesh_ni_inject.sv
// Bench for mesh_ni_inject: directed scenarios plus randomized traffic against a
// packet-level reference model (expected flit stream, packet and error counts).
module tb_mesh_ni_inject;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid, req_ready;
    logic [1:0]  req_dest_x, req_dest_y;
    logic [4:0]  req_len;
    logic [29:0] pld_data;
    logic        pld_valid, pld_ready;
    logic [31:0] flit_out_data;
    logic        flit_out_valid, flit_out_ready;
    logic        err_bad_req;
    logic [15:0] pkt_sent;

    always #5 clk = ~clk;

    mesh_ni_inject #(
        .DATA_WIDTH(32), .X_COORD(1), .Y_COORD(2),
        .MESH_SIZE_X(4), .MESH_SIZE_Y(4), .MAX_LEN(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dest_x(req_dest_x), .req_dest_y(req_dest_y), .req_len(req_len),
        .pld_data(pld_data), .pld_valid(pld_valid), .pld_ready(pld_ready),
        .flit_out_data(flit_out_data), .flit_out_valid(flit_out_valid),
        .flit_out_ready(flit_out_ready),
        .err_bad_req(err_bad_req), .pkt_sent(pkt_sent)
    );

    typedef struct { int dx; int dy; int len; } req_t;

    req_t        rq[$];
    logic [29:0] pq[$];
    logic [31:0] expq[$];
    int exp_pkt = 0;
    int n_checks = 0;
    int n_err = 0;
    int n_of, first_of, last_of;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Head flit from the field layout: dest_x, dest_y, src_x=1, src_y=2, len, type on top.
    function automatic logic [31:0] exp_head(input int dx, input int dy, input int len);
        logic [31:0] h;
        h = 32'(dx) | (32'(dy) << 2) | (32'd1 << 4) | (32'd2 << 6) | (32'(len) << 8);
        h[31:30] = (len == 0) ? 2'b11 : 2'b01;
        return h;
    endfunction

    task automatic add_req(input int dx, input int dy, input int len, input logic [29:0] seed);
        req_t r;
        logic [29:0] w;
        r.dx = dx; r.dy = dy; r.len = len;
        rq.push_back(r);
        if (len <= 16) begin
            expq.push_back(exp_head(dx, dy, len));
            for (int i = 0; i < len; i++) begin
                w = seed + 30'(i) * 30'h4444;
                pq.push_back(w);
                expq.push_back({(i == len - 1) ? 2'b10 : 2'b00, w});
            end
        end
    endtask

    // Entered and left at posedge+1. stall_after: hold ready low 5 cycles once that many flits left.
    task automatic run_engine(input int rdy_pct, input int vld_pct, input int stall_after, input int budget);
        int cyc = 0;
        int stall = 0;
        bit rf, pf, bad, err_exp, load_exp, hold_chk;
        logic [31:0] hold_data, e;
        n_of = 0; first_of = -1; last_of = -1;
        while ((rq.size() > 0 || expq.size() > 0) && cyc < budget) begin
            req_valid = (rq.size() > 0) && ($urandom_range(99) < vld_pct);
            if (rq.size() > 0) begin
                req_dest_x = 2'(rq[0].dx);
                req_dest_y = 2'(rq[0].dy);
                req_len    = 5'(rq[0].len);
            end
            pld_valid = (pq.size() > 0) && ($urandom_range(99) < vld_pct);
            if (pq.size() > 0) pld_data = pq[0];
            flit_out_ready = ($urandom_range(99) < rdy_pct);
            if (n_of == stall_after && stall < 5 && flit_out_valid) begin
                flit_out_ready = 1'b0;
                stall++;
            end
            #1;
            rf  = req_valid && req_ready;
            pf  = pld_valid && pld_ready;
            bad = rf && (rq[0].len > 16);
            hold_chk = flit_out_valid && !flit_out_ready;
            if (hold_chk) begin
                check_val("bp_req_ready", 32'(req_ready), 32'd0);
                check_val("bp_pld_ready", 32'(pld_ready), 32'd0);
                hold_data = flit_out_data;
            end
            if (flit_out_valid && flit_out_ready) begin
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    check_val("flit", flit_out_data, e);
                    if (e[31]) exp_pkt++;
                end else begin
                    check_val("unexpected_flit_valid", 32'(flit_out_valid), 32'd0);
                end
                n_of++;
                if (first_of < 0) first_of = cyc;
                last_of = cyc;
            end
            err_exp  = bad;
            load_exp = (rf && !bad) || pf;
            if (rf) void'(rq.pop_front());
            if (pf) void'(pq.pop_front());
            @(posedge clk); #1;
            cyc++;
            check_val("err_bad_req", 32'(err_bad_req), 32'(err_exp));
            if (load_exp) check_val("latency_valid", 32'(flit_out_valid), 32'd1);
            if (hold_chk) begin
                check_val("hold_valid", 32'(flit_out_valid), 32'd1);
                check_val("hold_data", flit_out_data, hold_data);
            end
            check_val("pkt_sent", 32'(pkt_sent), 32'(16'(exp_pkt)));
        end
        check_val("drain_timeout", 32'(rq.size() + expq.size()), 32'd0);
        req_valid = 1'b0;
        pld_valid = 1'b0;
        flit_out_ready = 1'b0;
    endtask

    initial begin
        req_valid = 1'b0; req_dest_x = 2'd0; req_dest_y = 2'd0; req_len = 5'd0;
        pld_data = 30'd0; pld_valid = 1'b0; flit_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid", 32'(flit_out_valid), 32'd0);
        check_val("rst_data", flit_out_data, 32'd0);
        check_val("rst_req_ready", 32'(req_ready), 32'd0);
        check_val("rst_pld_ready", 32'(pld_ready), 32'd0);
        check_val("rst_err", 32'(err_bad_req), 32'd0);
        check_val("rst_pkt", 32'(pkt_sent), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("req_ready_after_rst", 32'(req_ready), 32'd1);

        // Basic packet: 0x40000293, 0x00001234, 0x80005678 back to back.
        add_req(3, 0, 2, 30'h1234);
        run_engine(100, 100, -1, 50);
        check_val("basic_nflits", 32'(n_of), 32'd3);
        check_val("basic_contig", 32'(last_of - first_of + 1), 32'd3);

        // Single-flit packet must not consume the pending payload word.
        add_req(0, 0, 0, 30'd0);
        pq.push_back(30'h3ABC);
        run_engine(100, 100, -1, 50);
        check_val("single_nflits", 32'(n_of), 32'd1);
        check_val("single_no_pld", 32'(pq.size()), 32'd1);
        pq.delete();

        // Bad length followed by a good request.
        add_req(1, 1, 17, 30'd0);
        add_req(2, 3, 1, 30'h0777);
        run_engine(100, 100, -1, 50);
        check_val("badlen_nflits", 32'(n_of), 32'd2);

        // Backpressure mid-body.
        add_req(2, 1, 4, 30'h0100);
        run_engine(100, 100, 2, 60);
        check_val("bp_nflits", 32'(n_of), 32'd5);

        // Back-to-back len-1 packets with no bubble.
        add_req(0, 3, 1, 30'h0AAA);
        add_req(3, 3, 1, 30'h0BBB);
        run_engine(100, 100, -1, 50);
        check_val("b2b_nflits", 32'(n_of), 32'd4);
        check_val("b2b_contig", 32'(last_of - first_of + 1), 32'd4);

        // Randomized traffic including bad lengths.
        for (int k = 0; k < 40; k++) begin
            add_req($urandom_range(3), $urandom_range(3), $urandom_range(20), 30'($urandom));
        end
        run_engine(60, 70, -1, 5000);

        // Reset mid-packet after the head of a len-4 packet.
        req_valid = 1'b1; req_dest_x = 2'd2; req_dest_y = 2'd2; req_len = 5'd4;
        flit_out_ready = 1'b1; pld_valid = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_val("midrst_head_valid", 32'(flit_out_valid), 32'd1);
        check_val("midrst_head", flit_out_data, exp_head(2, 2, 4));
        #2 rst = 1'b1;
        #1;
        check_val("midrst_valid", 32'(flit_out_valid), 32'd0);
        check_val("midrst_pkt", 32'(pkt_sent), 32'd0);
        check_val("midrst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        exp_pkt = 0;
        flit_out_ready = 1'b0;
        @(posedge clk); #1;
        add_req(1, 3, 2, 30'h0555);
        run_engine(100, 100, -1, 50);
        check_val("postrst_nflits", 32'(n_of), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/mesh_ni_inject.md
# mesh_ni_inject

Injection-side network interface for the 2D mesh NoC. It takes packet requests from a processing element: a destination coordinate and a payload length, followed by the payload words. It turns them into head/body/tail flits and drives the router's local input port (`local_in_data/valid/ready`) with a registered valid/ready stream. It stamps source coordinates, validates requests and counts delivered packets.

## Interface
Parameters:
- `DATA_WIDTH`, 32: flit width. Top 2 bits are the flit type; payload words are `DATA_WIDTH-2` bits.
- `X_COORD`, 0: this node's X coordinate, written into the head flit's src_x field.
- `Y_COORD`, 0: this node's Y coordinate, written into the head flit's src_y field.
- `MESH_SIZE_X`, 4: mesh columns. `CX = max(1,$clog2(MESH_SIZE_X))`.
- `MESH_SIZE_Y`, 4: mesh rows. `CY = max(1,$clog2(MESH_SIZE_Y))`.
- `MAX_LEN`, 16: maximum payload flits per packet. `LENW = $clog2(MAX_LEN+1)`.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  packet request present.
- `req_ready`  out  1  request accepted on `req_valid & req_ready`.
- `req_dest_x`  in  CX  destination X.
- `req_dest_y`  in  CY  destination Y.
- `req_len`  in  LENW  payload flit count, 0..MAX_LEN.
- `pld_data`  in  DATA_WIDTH-2  payload word.
- `pld_valid`  in  1  payload word present.
- `pld_ready`  out  1  payload word accepted.
- `flit_out_data`  out  DATA_WIDTH  to router `local_in_data`.
- `flit_out_valid`  out  1  to router `local_in_valid`.
- `flit_out_ready`  in  1  from router `local_in_ready`.
- `err_bad_req`  out  1  one-cycle pulse when a request is dropped.
- `pkt_sent`  out  16  count of packets whose last flit handshook; wraps 0xFFFF→0.

## Operation
Flit type field `[DW-1:DW-2]`:
- 01 = HEAD
- 00 = BODY
- 10 = TAIL
- 11 = SINGLE (head-only packet)

Head/single flit fields, packed from bit 0:
- dest_x `[CX-1:0]`
- dest_y (CY bits)
- src_x (CX bits)
- src_y (CY bits)
- len (LENW bits)
- all remaining bits below the type field are 0.

Body/tail flits carry `pld_data` in `[DW-3:0]`.

Output register:
- `flit_out_*` is always a register.
- `slot_free = !flit_out_valid | flit_out_ready`.
- Data and valid hold steady while `valid & !ready`; a flit is never dropped or altered once valid.

FSM states: IDLE, BODY.
- **IDLE:** `req_ready = slot_free`.
  - On accept with `dest_x < MESH_SIZE_X`, `dest_y < MESH_SIZE_Y` and `1 ≤ len ≤ MAX_LEN`: load a HEAD flit, `remaining = len`, go to BODY.
  - On accept with `len == 0`: load a SINGLE flit, stay in IDLE.
  - Any other accepted request (dest out of range, or `len > MAX_LEN`): nothing is loaded, `err_bad_req` pulses the next cycle, stay in IDLE.
- **BODY:** `pld_ready = slot_free`, `req_ready = 0`.
  - Each accepted word loads BODY, or TAIL when `remaining == 1`, and decrements `remaining`.
  - After TAIL is loaded, go to IDLE.
- A destination equal to this node's own coordinates is legal; the router delivers it locally.
- `pkt_sent` increments on a handshake of a TAIL or SINGLE flit.

## Timing
- Reset values: `flit_out_valid=0`, `flit_out_data=0`, `req_ready=0`, `pld_ready=0`, `err_bad_req=0`, `pkt_sent=0`, FSM in IDLE, `remaining=0`.
  - `req_ready` goes to 1 in the first cycle after `rst` deasserts.
- Latency: a request or payload accepted in cycle N appears as valid on `flit_out_*` in cycle N+1.
- Full throughput: with `flit_out_ready` held high and `pld_valid` held high, a packet of len L takes L+1 consecutive cycles.
  - Back-to-back packets have no bubble: the IDLE accept happens in the same cycle the TAIL handshakes.
- Backpressure: while `flit_out_ready=0` and valid is set, `req_ready` and `pld_ready` are 0.
- Reset mid-packet: the packet is abandoned immediately and `flit_out_valid` drops asynchronously. The router shares `rst` and is cleared with this block.
- `err_bad_req` is exactly one cycle wide per bad request. Consecutive bad requests give consecutive pulses.

## Structure
- Shared package `mesh_noc_pkg` holds:
  - flit type constants (HEAD/BODY/TAIL/SINGLE);
  - head-field offset functions of (CX, CY, LENW);
  - a `build_head` function.
  The router and the future ejection NI use the same package.
- One natural sub-module: `mesh_flit_reg`, a valid/ready output pipeline register parameterised by width, reusable on router outputs.

## Test plan
Configuration for all scenarios: DW=32, X_COORD=1, Y_COORD=2, 4x4 mesh, MAX_LEN=16.
- **Basic packet:** request dest (3,0), len 2, payloads 0x1234 then 0x5678, ready held high.
  - Flits 0x4000_0293, 0x0000_1234, 0x8000_5678 on consecutive cycles; `pkt_sent`=1.
- **Single-flit packet:** request dest (0,0), len 0.
  - Flit 0xC000_0090; `pkt_sent` increments; no payload is consumed.
- **Bad length:** request with len 17.
  - `err_bad_req` pulses for 1 cycle; no `flit_out_valid`; next valid request is served normally.
- **Backpressure:** hold `flit_out_ready=0` for 5 cycles mid-body.
  - Data is stable throughout, `pld_ready=0`, the flit sequence is intact after release.
- **Back-to-back packets:** two len-1 packets with ready held high.
  - 4 flits in 4 consecutive cycles; `pkt_sent`=2.
- **Reset mid-packet:** assert `rst` after the head of a len-4 packet.
  - `flit_out_valid=0` immediately; `pkt_sent=0`; a new packet after reset starts with a HEAD flit.
